// File: rtl/aes_ctr_stream_ctrl_if.sv
// Command, message, result and AES core signal bundle for aes_ctr_stream_ctrl.
// The master drives jobs and data; the slave is the controller.
interface aes_ctr_stream_ctrl_if #(
    parameter int KEYLEN = 128,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic [KEYLEN-1:0] key_in;
    logic [63:0]       nonce_in;
    logic [63:0]       ctr_in;
    logic [CNT_W-1:0]  num_blocks;
    logic              in_valid;
    logic [KEYLEN-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [KEYLEN-1:0] out_data;
    logic              out_ready;
    logic [KEYLEN-1:0] aes_state;
    logic [KEYLEN-1:0] aes_key;
    logic [KEYLEN-1:0] aes_out;
    logic              busy;
    logic              done;
    logic              ctr_wrap;

    modport master (
        output start, abort, key_in, nonce_in, ctr_in, num_blocks,
               in_valid, in_data, out_ready, aes_out,
        input  in_ready, out_valid, out_data, aes_state, aes_key,
               busy, done, ctr_wrap
    );

    modport slave (
        input  start, abort, key_in, nonce_in, ctr_in, num_blocks,
               in_valid, in_data, out_ready, aes_out,
        output in_ready, out_valid, out_data, aes_state, aes_key,
               busy, done, ctr_wrap
    );
endinterface

// File: rtl/aes_ctr_stream_ctrl.sv
// AES-128 CTR sequencer: issues {nonce, counter} to a fixed-latency core, XORs the
// keystream with the delayed message and buffers results in a credit-guarded FIFO.
//
// state | meaning
// IDLE  | waiting for start; zero-block jobs complete here
// RUN   | accepting message blocks while blocks and credits remain
// DRAIN | all blocks issued; waiting for pipeline and FIFO to empty
module aes_ctr_stream_ctrl #(
    parameter int KEYLEN     = 128,
    parameter int AES_LAT    = 21,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 16
) (
    input logic                  clk,
    input logic                  rst,
    aes_ctr_stream_ctrl_if.slave bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nx;
    logic [KEYLEN-1:0] key_q;
    logic [63:0]       nonce_q;
    logic [63:0]       ctr_q;
    logic [CNT_W-1:0]  blocks_left;
    logic              ctr_wrap_q;
    logic              zero_done_q;
    logic [CW-1:0]     credits;

    logic              dly_v [AES_LAT];
    logic [KEYLEN-1:0] dly_d [AES_LAT];

    logic [KEYLEN-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    logic in_ready, issue, start_ok, any_inflight, drained;
    logic fifo_wr, fifo_pop, fifo_full, fifo_empty, done;

    assign start_ok   = (state == IDLE) && bus.start && !bus.abort;
    assign in_ready   = (state == RUN) && (blocks_left != '0) && (credits != '0);
    assign issue      = bus.in_valid && in_ready && !bus.abort;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_wr    = dly_v[AES_LAT-1] && !bus.abort;
    assign fifo_pop   = !fifo_empty && bus.out_ready && !bus.abort;
    assign drained    = !any_inflight && fifo_empty;

    always_comb begin
        any_inflight = 1'b0;
        for (int i = 0; i < AES_LAT; i++) begin
            any_inflight = any_inflight | dly_v[i];
        end
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok && (bus.num_blocks != '0)) state_nx = RUN;
            end
            RUN: begin
                if (issue && (blocks_left == CNT_W'(1))) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drained) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (zero_done_q) done = 1'b1;
        if (bus.abort) begin
            state_nx = IDLE;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            blocks_left <= '0;
            ctr_wrap_q  <= 1'b0;
            zero_done_q <= 1'b0;
            credits     <= CW'(FIFO_DEPTH);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            for (int i = 0; i < AES_LAT; i++) begin
                dly_v[i] <= 1'b0;
                dly_d[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            state       <= state_nx;
            zero_done_q <= start_ok && (bus.num_blocks == '0);

            if (start_ok) begin
                key_q       <= bus.key_in;
                nonce_q     <= bus.nonce_in;
                ctr_q       <= bus.ctr_in;
                blocks_left <= bus.num_blocks;
                ctr_wrap_q  <= 1'b0;
            end

            if (issue) begin
                ctr_q       <= ctr_q + 64'd1;
                blocks_left <= blocks_left - CNT_W'(1);
                if (&ctr_q) ctr_wrap_q <= 1'b1;
            end

            // The core cannot stall, so the delay line advances every cycle.
            dly_v[0] <= issue;
            dly_d[0] <= bus.in_data;
            for (int i = 1; i < AES_LAT; i++) begin
                dly_v[i] <= dly_v[i-1];
                dly_d[i] <= dly_d[i-1];
            end

            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= bus.aes_out ^ dly_d[AES_LAT-1];
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            credits <= credits - CW'(issue) + CW'(fifo_pop);

            if (bus.abort) begin
                for (int i = 0; i < AES_LAT; i++) begin
                    dly_v[i] <= 1'b0;
                end
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                credits  <= CW'(FIFO_DEPTH);
            end
        end
    end

    // Credits reserve a FIFO slot at issue, so a write can only meet a full FIFO alongside a pop.
    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        fifo_wr |-> (!fifo_full || fifo_pop));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.aes_state = {nonce_q, ctr_q};
    assign bus.aes_key   = key_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
    assign bus.ctr_wrap  = ctr_wrap_q;

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// Directed bench for aes_ctr_stream_ctrl with a 21-cycle stand-in core whose keystream
// is a fixed mix of state and key; expected results come from the bench's own model.
module tb_aes_ctr_stream_ctrl;

    localparam int LAT = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_ctr_stream_ctrl_if #(.KEYLEN(128), .CNT_W(16)) bus ();

    aes_ctr_stream_ctrl #(
        .KEYLEN(128), .AES_LAT(LAT), .FIFO_DEPTH(32), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [127:0] ks_f(input logic [127:0] s, input logic [127:0] k);
        return {s[63:0], s[127:64]} ^ k ^ 128'h5A5A_3C3C_0F0F_9696_A5A5_C3C3_F0F0_6969;
    endfunction

    function automatic logic [127:0] mk_data(input int i, input logic [63:0] nn);
        return {nn ^ 64'h0123_4567_89AB_CDEF, 32'hC0DE_0000, 32'(i)};
    endfunction

    logic [127:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= ks_f(bus.aes_state, bus.aes_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign bus.aes_out = core_pipe[LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [127:0] exp_q[$];
    int  r_first_acc, r_first_ov, r_last_pop, r_done_cyc, r_sent, r_got;
    int  r_sent_hold, r_wrap_sent, r_rdy_cnt;
    logic r_rdy_hold, r_done_seen;

    task automatic start_job(input logic [127:0] k, input logic [63:0] nn,
                             input logic [63:0] c0, input int n);
        bus.start      = 1'b1;
        bus.key_in     = k;
        bus.nonce_in   = nn;
        bus.ctr_in     = c0;
        bus.num_blocks = 16'(n);
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [127:0] k, input logic [63:0] nn,
                           input logic [63:0] c0, input int n, input int hold);
        logic [63:0]  ctr;
        logic [127:0] exp;
        ctr = c0;
        exp_q.delete();
        r_first_acc = -1; r_first_ov = -1; r_last_pop = -1; r_done_cyc = -1;
        r_sent = 0; r_got = 0; r_sent_hold = -1; r_wrap_sent = -1; r_rdy_cnt = 0;
        r_rdy_hold = 1'b0; r_done_seen = 1'b0;
        start_job(k, nn, c0, n);
        for (int cyc = 0; cyc < 600 && !r_done_seen; cyc++) begin
            bus.out_ready = (cyc >= hold);
            bus.in_valid  = (r_sent < n);
            bus.in_data   = mk_data(r_sent, nn);
            if (r_wrap_sent < 0 && bus.ctr_wrap) r_wrap_sent = r_sent;
            if (r_first_ov < 0 && bus.out_valid) r_first_ov = cyc;
            if (cyc == hold) begin
                r_sent_hold = r_sent;
                r_rdy_hold  = bus.in_ready;
            end
            if (bus.in_ready) r_rdy_cnt++;
            if (bus.in_valid && bus.in_ready) begin
                check_val({name, "_aes_state"}, bus.aes_state, {nn, ctr});
                check_val({name, "_aes_key"}, bus.aes_key, k);
                exp_q.push_back(mk_data(r_sent, nn) ^ ks_f({nn, ctr}, k));
                if (r_first_acc < 0) r_first_acc = cyc;
                r_sent++;
                ctr = ctr + 64'd1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val({name, "_unexpected_out"}, bus.out_data, 128'hx);
                end else begin
                    exp = exp_q.pop_front();
                    check_val($sformatf("%s_out%0d", name, r_got), bus.out_data, exp);
                end
                r_got++;
                r_last_pop = cyc;
            end
            if (bus.done) begin
                r_done_seen = 1'b1;
                r_done_cyc  = cyc;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_val({name, "_done_seen"}, 128'(r_done_seen), 128'd1);
        check_val({name, "_out_count"}, 128'(r_got), 128'(n));
        check_val({name, "_ready_cycles"}, 128'(r_rdy_cnt), 128'(n));
        check_val({name, "_out_latency"}, 128'(r_first_ov - r_first_acc), 128'(LAT + 1));
        check_val({name, "_done_after_pop"}, 128'(r_done_cyc - r_last_pop), 128'd1);
        check_val({name, "_idle_after"}, 128'(bus.busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cnt;
        bus.start = 0; bus.abort = 0; bus.key_in = '0; bus.nonce_in = '0; bus.ctr_in = '0;
        bus.num_blocks = '0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check_val("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_val("rst_done", 128'(bus.done), 128'd0);
        check_val("rst_busy", 128'(bus.busy), 128'd0);
        check_val("rst_ctr_wrap", 128'(bus.ctr_wrap), 128'd0);
        check_val("rst_aes_key", bus.aes_key, 128'd0);
        check_val("rst_aes_state", bus.aes_state, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: four back-to-back blocks, no backpressure
        run_job("t1", 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 64'd1, 64'd0, 4, 0);
        check_val("t1_no_wrap", 128'(r_wrap_sent), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);

        // T2: out_ready held low; credits must stop issue at FIFO depth
        run_job("t2", 128'h1111_2222_3333_4444_5555_6666_7777_8888, 64'hABCD, 64'h100, 40, 60);
        check_val("t2_accepts_at_hold", 128'(r_sent_hold), 128'd32);
        check_val("t2_ready_at_hold", 128'(r_rdy_hold), 128'd0);

        // T3: counter wraps after the second block
        run_job("t3", 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 64'h77,
                64'hFFFF_FFFF_FFFF_FFFE, 3, 0);
        check_val("t3_wrap_after_2nd", 128'(r_wrap_sent), 128'd2);
        @(negedge clk);
        check_val("t3_wrap_sticky_idle", 128'(bus.ctr_wrap), 128'd1);

        // T4: zero-block job
        check_val("t4_busy_at_start", 128'(bus.busy), 128'd0);
        start_job(128'h5, 64'h5, 64'h5, 0);
        check_val("t4_done_next", 128'(bus.done), 128'd1);
        check_val("t4_busy_next", 128'(bus.busy), 128'd0);
        @(negedge clk);
        check_val("t4_done_pulse_end", 128'(bus.done), 128'd0);
        check_val("t4_busy_after", 128'(bus.busy), 128'd0);

        // T5: abort ten cycles into a 16-block job
        start_job(128'h99, 64'h99, 64'h200, 16);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_data(i, 64'h99);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_val("t5_busy_before_abort", 128'(bus.busy), 128'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        check_val("t5_idle_after_abort", 128'(bus.busy), 128'd0);
        check_val("t5_out_valid_after_abort", 128'(bus.out_valid), 128'd0);
        check_val("t5_in_ready_after_abort", 128'(bus.in_ready), 128'd0);
        check_val("t5_no_done_on_abort", 128'(bus.done), 128'd0);
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid || bus.done) ov_cnt++;
            @(negedge clk);
        end
        check_val("t5_no_late_output", 128'(ov_cnt), 128'd0);
        run_job("t5b", 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 64'h3, 64'h40, 5, 0);

        // T6: asynchronous reset while draining
        start_job(128'hCAFE, 64'h6, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_data(i, 64'h6);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (25) @(negedge clk);
        check_val("t6_busy_in_drain", 128'(bus.busy), 128'd1);
        check_val("t6_out_valid_in_drain", 128'(bus.out_valid), 128'd1);
        check_val("t6_wrap_in_drain", 128'(bus.ctr_wrap), 128'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_async_busy", 128'(bus.busy), 128'd0);
        check_val("t6_async_out_valid", 128'(bus.out_valid), 128'd0);
        check_val("t6_async_in_ready", 128'(bus.in_ready), 128'd0);
        check_val("t6_async_done", 128'(bus.done), 128'd0);
        check_val("t6_async_wrap", 128'(bus.ctr_wrap), 128'd0);
        check_val("t6_async_key", bus.aes_key, 128'd0);
        check_val("t6_async_state", bus.aes_state, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job("t6b", 128'h1234, 64'h9, 64'h7, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
